// File: rtl/bp_fifo_pkg.sv
// BytePipe shared definitions: byte width, byte type and handshake helper.
package bp_fifo_pkg;

  localparam int BP_W = 8;

  typedef logic [BP_W-1:0] bp_byte_t;

  // A BytePipe transfer completes when valid and ready are both high.
  function automatic logic bp_fire(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/bp_fifo_if.sv
// BytePipe link: one byte with valid/ready flow control.
interface bp_fifo_if;
  import bp_fifo_pkg::*;

  bp_byte_t data;
  logic     valid;
  logic     ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bp_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// The contents are not reset; the pointers decide which entries are live.
module bp_fifo_mem
  import bp_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  bp_byte_t          wdata,
  input  logic [ADDR_W-1:0] raddr,
  output bp_byte_t          rdata
);

  bp_byte_t mem [DEPTH];

  // Write the pushed byte into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bp_fifo.sv
// BytePipe byte FIFO with a registered head, occupancy, almost-full and a
// sticky drop flag. The i_cg input freezes all state and masks both
// handshakes so no transfer can complete in a gated cycle.
module bp_fifo
  import bp_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cg,
  input  logic            i_flush,
  bp_fifo_if.slave        up,
  bp_fifo_if.master       dn,
  output logic [ADDR_W:0] o_count,
  output logic            o_afull,
  output logic            o_drop
);

  localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W + 1)'(AFULL_LVL);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_next;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  bp_byte_t          head_p1;
  bp_byte_t          mem_rdata;

  // The extra pointer MSB separates full from empty when the addresses match.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign rd_next = rd_ptr[ADDR_W-1:0] + ADDR_ONE;

  assign up.ready = i_cg && !full;
  assign dn.valid = i_cg && !empty;
  assign dn.data  = head_p1;

  assign push = bp_fire(up.valid, up.ready);
  assign pop  = bp_fire(dn.valid, dn.ready);

  assign o_count = count;
  assign o_afull = (count >= AFULL_CNT);

  bp_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (up.data),
    .raddr (rd_next),
    .rdata (mem_rdata)
  );

  // Pointer and drop-flag control: reset beats flush; gating holds everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_drop <= 1'b0;
    end else if (i_cg) begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        o_drop <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (up.valid && full) o_drop <= 1'b1;
      end
    end
  end

  // ---- stage p1: head register always mirrors the oldest live entry ----
  // A pop with a second entry behind it loads that entry from storage; a push
  // into an empty FIFO, or replacing the only entry as it leaves, takes the
  // incoming byte directly so it appears one cycle after the push.
  always_ff @(posedge i_clk) begin
    if (pop && (count != PTR_ONE)) begin
      head_p1 <= mem_rdata;
    end else if (push && (empty || pop)) begin
      head_p1 <= up.data;
    end
  end

endmodule
